// File: rtl/load_store_unit.sv
// Load/store unit sequencing single-word memory accesses for byte, half and
// word loads and stores. Sub-word stores use read-modify-write on the
// containing word. Each memory access holds its enable for ACCESS_CYCLES.
//
// Ports:
//   clock, reset          rising-edge clock, async active-high reset
//   start                 request strobe, sampled only in IDLE
//   is_store, op          1=store/0=load; op[1:0] size, op[2] zero-extend
//   address, store_data   byte address and store source
//   busy, done, fault     status; fault is valid while done is high
//   load_data             extended load result, held until the next load
//   mem_read, mem_write   memory enables (never both high)
//   mem_address           word index of the access
//   mem_write_data        word driven to memory during WRITE
//   mem_read_data         word from memory, valid on the last read cycle
//
// state | meaning
// IDLE  | waiting for start
// READ  | mem_read held for ACCESS_CYCLES cycles
// WRITE | mem_write held for ACCESS_CYCLES cycles
// DONE  | one-cycle completion pulse
module load_store_unit #(
  parameter int ACCESS_CYCLES = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  op,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] load_data,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_DONE} state_t;

  localparam logic [3:0] LP_LAST = 4'(ACCESS_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic        r_is_store;
  logic [2:0]  r_op;
  logic [31:0] r_addr;
  logic [15:0] r_sdata;
  logic        r_fault;
  logic [31:0] r_load_data;
  logic [31:0] r_wdata;

  logic        w_last;
  logic        w_in_fault;
  logic        w_in_sw;
  logic [31:0] w_byte_sh;
  logic [31:0] w_half_sh;
  logic [31:0] w_load_ext;
  logic [31:0] w_mask;
  logic [31:0] w_rep;
  logic [31:0] w_merged;

  assign w_last = (r_cnt == LP_LAST);

  // The start-edge routing decision must use the request being latched on
  // that same edge; everything after it works from the latched copy.
  assign w_in_fault = (op[1:0] == 2'b11) ||
                      ((op[1:0] == 2'b01) && address[0]) ||
                      ((op[1:0] == 2'b10) && (address[1:0] != 2'b00));
  assign w_in_sw    = is_store && (op[1:0] == 2'b10);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (w_in_fault)   w_next = ST_DONE;
          else if (w_in_sw) w_next = ST_WRITE;
          else              w_next = ST_READ;
        end
      end
      ST_READ:  if (w_last) w_next = r_is_store ? ST_WRITE : ST_DONE;
      ST_WRITE: if (w_last) w_next = ST_DONE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from state only, so reset drops the enables immediately.
  always_comb begin
    busy      = (r_state != ST_IDLE);
    done      = (r_state == ST_DONE);
    fault     = (r_state == ST_DONE) && r_fault;
    mem_read  = (r_state == ST_READ);
    mem_write = (r_state == ST_WRITE);
  end

  assign mem_address    = {2'b00, r_addr[31:2]};
  assign load_data      = r_load_data;
  assign mem_write_data = r_wdata;

  // Lane extraction for loads (little-endian lanes).
  assign w_byte_sh = mem_read_data >> {r_addr[1:0], 3'b000};
  assign w_half_sh = mem_read_data >> {r_addr[1], 4'b0000};

  always_comb begin
    case (r_op[1:0])
      2'b00:   w_load_ext = r_op[2] ? {24'b0, w_byte_sh[7:0]}
                                    : {{24{w_byte_sh[7]}}, w_byte_sh[7:0]};
      2'b01:   w_load_ext = r_op[2] ? {16'b0, w_half_sh[15:0]}
                                    : {{16{w_half_sh[15]}}, w_half_sh[15:0]};
      default: w_load_ext = mem_read_data;
    endcase
  end

  // Lane merge for sub-word stores: replicate the source across all lanes
  // and let the mask pick the addressed one.
  assign w_mask   = (r_op[1:0] == 2'b00) ? (32'h0000_00FF << {r_addr[1:0], 3'b000})
                                         : (32'h0000_FFFF << {r_addr[1], 4'b0000});
  assign w_rep    = (r_op[1:0] == 2'b00) ? {4{r_sdata[7:0]}} : {2{r_sdata}};
  assign w_merged = (mem_read_data & ~w_mask) | (w_rep & w_mask);

  // Request latch and data capture
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_is_store  <= 1'b0;
      r_op        <= 3'b000;
      r_addr      <= 32'b0;
      r_sdata     <= 16'b0;
      r_fault     <= 1'b0;
      r_load_data <= 32'b0;
      r_wdata     <= 32'b0;
    end else begin
      if ((r_state == ST_IDLE) && start) begin
        r_is_store <= is_store;
        r_op       <= op;
        r_addr     <= address;
        r_sdata    <= store_data[15:0];
        r_fault    <= w_in_fault;
        if (w_in_sw && !w_in_fault) r_wdata <= store_data;
      end
      if ((r_state == ST_READ) && w_last) begin
        if (r_is_store) r_wdata     <= w_merged;
        else            r_load_data <= w_load_ext;
      end
    end
  end

  // Access-window counter, cleared whenever the state changes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= 4'd0;
    end else if (w_next != r_state) begin
      r_cnt <= 4'd0;
    end else if ((r_state == ST_READ) || (r_state == ST_WRITE)) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

endmodule
